// File: rtl/mem_access_stage.sv
// Memory-access stage: one load/store at a time, registered memory
// drive with a setup cycle before each write strobe, load data to writeback.
// Ports: clk, rst (async, active-high); req_* request handshake from execute;
// mem_* data memory address/control/data; wb_* load result handshake.
// Optional MEM_ACCESS_STATS_EN adds saturating load_count/store_count.
module mem_access_stage #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int RD_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [RD_W-1:0]   req_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
`ifdef MEM_ACCESS_STATS_EN
  output logic [RD_W-1:0]   wb_rd,
  output logic [15:0]       load_count,
  output logic [15:0]       store_count
`else
  output logic [RD_W-1:0]   wb_rd
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_wb_data;
  logic [RD_W-1:0]   r_rd;
  logic [RD_W-1:0]   r_wb_rd;
  logic              r_wr;

  logic w_accept;
  logic w_wb_hs;
  logic w_capture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Outputs decode from state only: no input-to-output path.
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    mem_read  = 1'b1;
    wb_valid  = 1'b0;
    w_accept  = 1'b0;
    w_wb_hs   = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept = 1'b1;
          w_next   = SETUP;
        end
      end
      SETUP: begin
        w_capture = !r_wr;
        w_next    = r_wr ? STROBE : RESP;
      end
      STROBE: begin
        mem_read = 1'b0;
        w_next   = IDLE;
      end
      RESP: begin
        wb_valid = 1'b1;
        if (wb_ready) begin
          w_wb_hs = 1'b1;
          w_next  = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rd      <= '0;
      r_wr      <= 1'b0;
      r_wb_data <= '0;
      r_wb_rd   <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_rd    <= req_rd;
        r_wr    <= req_wr;
      end
      if (w_capture) begin
        r_wb_data <= mem_rdata;
        r_wb_rd   <= r_rd;
      end
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign wb_data   = r_wb_data;
  assign wb_rd     = r_wb_rd;

`ifdef MEM_ACCESS_STATS_EN
  logic [15:0] r_load_count;
  logic [15:0] r_store_count;
  logic        w_strobe;

  assign w_strobe = !mem_read;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_load_count  <= '0;
      r_store_count <= '0;
    end else begin
      if (w_wb_hs && r_load_count != 16'hFFFF)
        r_load_count <= r_load_count + 16'd1;
      if (w_strobe && r_store_count != 16'hFFFF)
        r_store_count <= r_store_count + 16'd1;
    end
  end

  assign load_count  = r_load_count;
  assign store_count = r_store_count;
`endif

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the 16-bit Harvard processor, sitting directly upstream of the data memory. It accepts one load/store request at a time from execute over a valid/ready handshake and drives the data memory's address, read/write control and write data from registers. It captures load data and hands it to writeback over a second valid/ready handshake. Because the data memory is level-sensitive, the address and write data are stable for a full cycle before and during every write strobe.

## Interface
- ADDR_W, 5: data memory address width.
- DATA_W, 16: data word width.
- RD_W, 3: destination register index width.

- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  execute presents a request.
- req_ready  out  1  stage can accept; high only in IDLE.
- req_wr  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  memory address.
- req_wdata  in  DATA_W  store data.
- req_rd  in  RD_W  load destination register.
- mem_addr  out  ADDR_W  registered address to the data memory.
- mem_read  out  1  1 = read, 0 = write strobe.
- mem_wdata  out  DATA_W  registered write data to the data memory.
- mem_rdata  in  DATA_W  combinational read data from the data memory.
- wb_valid  out  1  load result available.
- wb_ready  in  1  writeback accepts the result.
- wb_data  out  DATA_W  captured load data.
- wb_rd  out  RD_W  destination register of the result.

## Operation
- States: IDLE, SETUP, STROBE, RESP.
- IDLE: req_ready=1. On req_valid:
  - Register req_addr into mem_addr, req_wdata into mem_wdata, and req_rd/req_wr internally.
  - Go to SETUP.
- SETUP: mem_read=1 and the address is stable.
  - Load: capture mem_rdata into wb_data and the stored rd into wb_rd at the end of the cycle, then go to RESP.
  - Store: go to STROBE.
- STROBE (stores only): mem_read=0 for exactly one cycle, with mem_addr and mem_wdata unchanged. Then go to IDLE.
- RESP: wb_valid=1, with wb_data and wb_rd held stable. On wb_ready, go to IDLE. Otherwise stay in RESP indefinitely.
- mem_read is 1 in every state except STROBE, so a spurious write is never generated.
- mem_addr and mem_wdata change only on the accept edge and hold their values until the next accept.
- Stores produce no writeback transaction.
- Reset values: state IDLE, req_ready=1, mem_addr=0, mem_read=1, mem_wdata=0, wb_valid=0, wb_data=0, wb_rd=0. All counters are 0.
- Reset asserted mid-operation:
  - The operation is aborted immediately and asynchronously. mem_read returns to 1, so a store in STROBE is cut short.
  - A pending load result is dropped.
  - No request is accepted while rst=1.
- req_* inputs are ignored outside IDLE.
- wb_ready is ignored outside RESP.

## Timing
- Request accepted on edge N (req_valid & req_ready):
  - Load: wb_valid rises after edge N+1. Data reflects the memory contents at mem_addr during cycle N+1.
  - Store: mem_read is low from edge N+1 to edge N+2, and req_ready returns high after edge N+2.
- Throughput:
  - Stores: one per 3 cycles.
  - Loads: one per 3 cycles with wb_ready held high; longer under backpressure.
- wb_valid falls on the edge where wb_ready is sampled high in RESP. The same edge returns to IDLE, and a new request can be accepted one edge later.
- There is no combinational path from any req_* or wb_ready input to any output.

## Configuration
- MEM_ACCESS_STATS_EN defined:
  - Adds outputs load_count and store_count, 16 bits each.
  - load_count increments on each RESP handshake.
  - store_count increments on each STROBE cycle.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and their counters do not exist. All other behaviour is identical.

## Test plan
- Reset, with the memory preloaded as memory[i]=i:
  - All outputs equal their reset values.
  - Load addr 7, rd 3, wb_ready=1 → wb_valid=1 after the second edge, wb_data=7, wb_rd=3, req_ready high one edge later.
- Store addr 12, data 16'hBEEF, then load addr 12:
  - mem_read is low for exactly one cycle, with mem_addr=12 and mem_wdata=16'hBEEF stable from the cycle before.
  - The load returns 16'hBEEF.
- Load addr 5 with wb_ready=0 for 4 cycles:
  - wb_valid stays high with wb_data=5 throughout, and req_ready stays low.
  - Raising wb_ready completes the transfer in one cycle.
- rst pulsed while in STROBE of a store to addr 20 with data 99:
  - mem_read goes high immediately and the state returns to IDLE.
  - A later load of addr 20 returns 20 when the pulse lands before the strobe cycle has elapsed.
- Back-to-back requests with req_valid held high, wb_ready high:
  - Alternating store and load sequence of 10 operations.
  - One acceptance every 3 cycles, and no mem_read low outside STROBE.
  - With MEM_ACCESS_STATS_EN defined: load_count=5, store_count=5.
